// File: rtl/bankroll_ledger_if.sv
// +--------------------------------------------------------------------------+
// | bankroll_ledger_if : round-control and balance bus of the money ledger   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

interface bankroll_ledger_if;
  logic              new_game;
  logic [7:0]        bet_req;
  logic              round_start;
  logic              result_valid;
  logic [1:0]        result;
  logic signed [7:0] total_money;
  logic [7:0]        bet_locked;
  logic              bet_ok;
  logic              busy;
  logic              settled;
  logic              broke;

  modport master (
    output new_game, bet_req, round_start, result_valid, result,
    input  total_money, bet_locked, bet_ok, busy, settled, broke
  );

  modport slave (
    input  new_game, bet_req, round_start, result_valid, result,
    output total_money, bet_locked, bet_ok, busy, settled, broke
  );
endinterface

`default_nettype wire

// File: rtl/bankroll_ledger.sv
// +--------------------------------------------------------------------------+
// | bankroll_ledger : locks a clamped bet per round and settles the balance  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module bankroll_ledger #(
  parameter logic signed [7:0] START_MONEY = 8'sd100,
  parameter logic        [7:0] MIN_BET     = 8'd1,
  parameter logic        [7:0] MAX_BET     = 8'd50
) (
  input  wire logic         clk,
  input  wire logic         rst,
  bankroll_ledger_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_SETTLE = 2'd2,
    ST_BROKE  = 2'd3
  } state_t;

  state_t             r_state, w_state_n;
  logic signed [7:0]  r_total, w_total_n;
  logic        [7:0]  r_bet, w_bet_n;
  logic               r_ok, w_ok_n;
  logic               r_busy, w_busy_n;
  logic               r_settled, w_settled_n;
  logic               r_broke, w_broke_n;
  logic signed [9:0]  r_delta, w_delta_n;

  logic        [7:0]  w_clamp;
  logic               w_clamp_ok;
  logic signed [9:0]  w_bet10;
  logic signed [9:0]  w_delta;
  logic signed [9:0]  w_sum;
  logic signed [7:0]  w_sat;

  // Bet clamp: range limits first, then never stake more than is held.
  always_comb begin
    w_clamp    = bus.bet_req;
    w_clamp_ok = 1'b1;
    if (w_clamp < MIN_BET) begin
      w_clamp    = MIN_BET;
      w_clamp_ok = 1'b0;
    end
    if (w_clamp > MAX_BET) begin
      w_clamp    = MAX_BET;
      w_clamp_ok = 1'b0;
    end
    if (!r_total[7] && (w_clamp > $unsigned(r_total))) begin
      w_clamp    = $unsigned(r_total);
      w_clamp_ok = 1'b0;
    end
  end

  always_comb begin
    w_bet10 = $signed({2'b00, r_bet});
    w_delta = 10'sd0;
    case (bus.result)
      2'b00:   w_delta = -w_bet10;
      2'b01:   w_delta = 10'sd0;
      2'b10:   w_delta = w_bet10;
      default: w_delta = w_bet10 + $signed({3'b000, r_bet[7:1]});
    endcase
  end

  always_comb begin
    w_sum = $signed({{2{r_total[7]}}, r_total}) + r_delta;
    if (w_sum > 10'sd127) begin
      w_sat = 8'sd127;
    end else if (w_sum < -10'sd128) begin
      w_sat = -8'sd128;
    end else begin
      w_sat = w_sum[7:0];
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_total_n   = r_total;
    w_bet_n     = r_bet;
    w_ok_n      = r_ok;
    w_delta_n   = r_delta;
    w_settled_n = 1'b0;
    w_broke_n   = r_broke;
    case (r_state)
      ST_IDLE: begin
        if (bus.round_start) begin
          w_state_n = ST_LOCKED;
          w_bet_n   = w_clamp;
          w_ok_n    = w_clamp_ok;
        end
      end
      ST_LOCKED: begin
        if (bus.result_valid) begin
          w_delta_n = w_delta;
          w_state_n = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        w_total_n   = w_sat;
        w_settled_n = 1'b1;
        if (w_sat <= 8'sd0) begin
          w_state_n = ST_BROKE;
          w_broke_n = 1'b1;
        end else begin
          w_state_n = ST_IDLE;
        end
      end
      ST_BROKE: begin
        w_state_n = ST_BROKE;
      end
      default: begin
        w_state_n = ST_IDLE;
      end
    endcase
    // Outputs are registered, so busy follows the state being entered.
    w_busy_n = (w_state_n == ST_LOCKED) || (w_state_n == ST_SETTLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_total   <= START_MONEY;
      r_bet     <= 8'd0;
      r_ok      <= 1'b1;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
      r_broke   <= 1'b0;
      r_delta   <= 10'sd0;
    end else if (bus.new_game) begin
      r_state   <= ST_IDLE;
      r_total   <= START_MONEY;
      r_bet     <= 8'd0;
      r_ok      <= 1'b1;
      r_busy    <= 1'b0;
      r_settled <= 1'b0;
      r_broke   <= 1'b0;
      r_delta   <= 10'sd0;
    end else begin
      r_state   <= w_state_n;
      r_total   <= w_total_n;
      r_bet     <= w_bet_n;
      r_ok      <= w_ok_n;
      r_busy    <= w_busy_n;
      r_settled <= w_settled_n;
      r_broke   <= w_broke_n;
      r_delta   <= w_delta_n;
    end
  end

  assign bus.total_money = r_total;
  assign bus.bet_locked  = r_bet;
  assign bus.bet_ok      = r_ok;
  assign bus.busy        = r_busy;
  assign bus.settled     = r_settled;
  assign bus.broke       = r_broke;

endmodule

`default_nettype wire

// File: tb/tb_bankroll_ledger.sv
// +--------------------------------------------------------------------------+
// | tb_bankroll_ledger : directed and random rounds against a ledger model   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_bankroll_ledger;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  // Reference state: plain integers, no notion of the DUT's encoding.
  int   m_bal;
  int   m_bet;
  int   m_ok;
  int   m_broke;

  bankroll_ledger_if bus ();

  bankroll_ledger dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp_of(input int req, input int bal, output int ok);
    int v;
    v  = req;
    ok = 1;
    if (v < 1)   begin v = 1;   ok = 0; end
    if (v > 50)  begin v = 50;  ok = 0; end
    if (v > bal) begin v = bal; ok = 0; end
    return v;
  endfunction

  function automatic int payout(input int bet, input int res);
    case (res)
      0:       return -bet;
      1:       return 0;
      2:       return bet;
      default: return bet + bet / 2;
    endcase
  endfunction

  task automatic model_reset();
    m_bal   = 100;
    m_bet   = 0;
    m_ok    = 1;
    m_broke = 0;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".total"},  bus.total_money, m_bal);
    chk({tag, ".bet"},    bus.bet_locked,  m_bet);
    chk({tag, ".ok"},     bus.bet_ok,      m_ok);
    chk({tag, ".busy"},   bus.busy,        0);
    chk({tag, ".broke"},  bus.broke,       m_broke);
  endtask

  task automatic pulse_new_game();
    @(negedge clk);
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    model_reset();
  endtask

  // One full round, checking every cycle of the latency chain.
  task automatic do_round(input int req, input int res);
    int sum;
    @(negedge clk);
    bus.bet_req     = 8'(req);
    bus.round_start = 1'b1;
    @(negedge clk);
    bus.round_start = 1'b0;
    m_bet = clamp_of(req, m_bal, m_ok);
    chk("lock.bet",  bus.bet_locked, m_bet);
    chk("lock.ok",   bus.bet_ok,     m_ok);
    chk("lock.busy", bus.busy,       1);
    bus.result       = 2'(res);
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    chk("res.total",   bus.total_money, m_bal);
    chk("res.settled", bus.settled,     0);
    chk("res.busy",    bus.busy,        1);
    @(negedge clk);
    sum = m_bal + payout(m_bet, res);
    if (sum > 127)  sum = 127;
    if (sum < -128) sum = -128;
    m_bal = sum;
    if (m_bal <= 0) m_broke = 1;
    chk("set.total",   bus.total_money, m_bal);
    chk("set.settled", bus.settled,     1);
    chk("set.broke",   bus.broke,       m_broke);
    chk("set.busy",    bus.busy,        0);
    @(negedge clk);
    chk("post.settled", bus.settled, 0);
    chk("post.bet",     bus.bet_locked, m_bet);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst              = 1'b0;
    bus.new_game     = 1'b0;
    bus.bet_req      = 8'd0;
    bus.round_start  = 1'b0;
    bus.result_valid = 1'b0;
    bus.result       = 2'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_idle("reset");
    chk("reset.settled", bus.settled, 0);
    rst = 1'b1;
    @(negedge clk);
    check_idle("after_reset");

    do_round(10, 2);                        // 100 -> 110
    pulse_new_game();
    check_idle("ng1");
    do_round(7, 3);                         // blackjack: +7+3 -> 110
    chk("bj.total", bus.total_money, 110);
    do_round(7, 1);                         // push, settled still pulses
    do_round(200, 0);                       // clamp to 50 -> 60
    chk("clamp.hi", bus.bet_locked, 50);
    do_round(0, 1);                         // clamp to 1
    chk("clamp.lo", bus.bet_locked, 1);
    do_round(30, 0);                        // 60 -> 30
    do_round(45, 1);                        // clamp to balance 30
    chk("clamp.bal", bus.bet_locked, 30);
    do_round(30, 0);                        // 30 -> 0, broke
    chk("broke.flag", bus.broke, 1);

    // Broke: round_start and result_valid are both ignored.
    @(negedge clk);
    bus.bet_req     = 8'd5;
    bus.round_start = 1'b1;
    @(negedge clk);
    bus.round_start  = 1'b0;
    bus.result       = 2'd2;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    @(negedge clk);
    check_idle("broke.hold");
    chk("broke.settled", bus.settled, 0);
    pulse_new_game();
    check_idle("ng2");

    do_round(20, 2);                        // 100 -> 120
    do_round(50, 3);                        // 120 + 75 saturates
    chk("sat.total", bus.total_money, 127);

    // Abandon a locked round with new_game; a stale result must be ignored.
    @(negedge clk);
    bus.bet_req     = 8'd9;
    bus.round_start = 1'b1;
    @(negedge clk);
    bus.round_start = 1'b0;
    chk("abandon.busy", bus.busy, 1);
    pulse_new_game();
    check_idle("abandon");
    bus.result       = 2'd2;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    @(negedge clk);
    check_idle("abandon.stale");
    chk("abandon.settled", bus.settled, 0);

    // round_start and result_valid together in IDLE: the lock wins.
    @(negedge clk);
    bus.bet_req      = 8'd12;
    bus.round_start  = 1'b1;
    bus.result       = 2'd2;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.round_start  = 1'b0;
    bus.result_valid = 1'b0;
    m_bet = clamp_of(12, m_bal, m_ok);
    chk("both.busy", bus.busy, 1);
    chk("both.bet",  bus.bet_locked, 12);
    @(negedge clk);
    chk("both.settled", bus.settled, 0);
    chk("both.total",   bus.total_money, 100);
    chk("both.busy2",   bus.busy, 1);
    bus.result       = 2'd0;
    bus.result_valid = 1'b1;
    @(negedge clk);
    bus.result_valid = 1'b0;
    @(negedge clk);
    m_bal = 88;
    chk("both.final", bus.total_money, m_bal);
    chk("both.set",   bus.settled, 1);

    // Random rounds, with occasional stray results while idle.
    for (int i = 0; i < 60; i++) begin
      if (m_broke != 0) begin
        pulse_new_game();
        check_idle("rnd.ng");
      end
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.result       = 2'($urandom_range(0, 3));
        bus.result_valid = 1'b1;
        @(negedge clk);
        bus.result_valid = 1'b0;
        @(negedge clk);
        check_idle("rnd.stray");
      end
      do_round(int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
